// File: rtl/gb_dma_engine.sv
// gb_dma_engine: Game Boy OAM DMA (FF46) and CGB HDMA (FF51-FF55) engine.
// One shared read port; every byte is read in one cycle and written the next.
module gb_dma_engine #(
    parameter int OAM_LEN    = 160,
    parameter int OAM_DELAY  = 1,
    parameter int HDMA_BLOCK = 16,
    parameter int HDMA_EN    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_write_en,
    input  logic        reg_read_en,
    output logic [7:0]  reg_rdata,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        hblank,
    input  logic        lcd_on,
    output logic        oam_busy,
    output logic        cpu_stall
);
    localparam int DLY_W = (OAM_DELAY > 1) ? $clog2(OAM_DELAY) : 1;
    localparam int BLK_W = (HDMA_BLOCK > 1) ? $clog2(HDMA_BLOCK) : 1;

    typedef enum logic [1:0] {O_IDLE, O_DELAY, O_XFER} oam_state_t;
    typedef enum logic [1:0] {H_IDLE, H_GP, H_HB_WAIT, H_HB_BLOCK} hdma_state_t;

    oam_state_t        oam_state, oam_next;
    logic [7:0]        oam_src;
    logic [7:0]        oam_idx;
    logic [DLY_W-1:0]  oam_dly;
    logic [7:0]        oam_src_eff;
    logic              oam_rd, oam_last;

    hdma_state_t       hdma_state, hdma_next;
    logic [15:0]       hdma_src, src_next;
    logic [12:0]       hdma_dst, dst_next;
    logic [7:0]        blocks_left;
    logic [6:0]        blocks_m1;
    logic [BLK_W-1:0]  byte_cnt;
    logic              cancel_pend, cancel_req, hblank_q, hb_rise;
    logic              hdma_xfer, hdma_rd, blk_last, hdma_start;

    logic              vld_p1, oam_wr_p1, hdma_wr_p1;
    logic [15:0]       wr_addr_p1;

    logic              hdma_map;
    logic              wr_ff46, wr_ff51, wr_ff52, wr_ff53, wr_ff54, wr_ff55;

    assign hdma_map = (HDMA_EN != 0);
    assign wr_ff46  = reg_write_en && (reg_addr == 16'hFF46);
    assign wr_ff51  = hdma_map && reg_write_en && (reg_addr == 16'hFF51);
    assign wr_ff52  = hdma_map && reg_write_en && (reg_addr == 16'hFF52);
    assign wr_ff53  = hdma_map && reg_write_en && (reg_addr == 16'hFF53);
    assign wr_ff54  = hdma_map && reg_write_en && (reg_addr == 16'hFF54);
    assign wr_ff55  = hdma_map && reg_write_en && (reg_addr == 16'hFF55);

    // Echo-RAM sources E0-FF fold back onto C0-DF
    assign oam_src_eff = (oam_src >= 8'hE0) ? (oam_src - 8'h20) : oam_src;
    assign oam_rd      = (oam_state == O_XFER);
    assign oam_last    = (oam_idx == 8'(OAM_LEN - 1));

    // OAM next state; an FF46 write always (re)starts from the delay phase
    always_comb begin
        oam_next = oam_state;
        case (oam_state)
            O_DELAY: if (oam_dly == DLY_W'(OAM_DELAY - 1)) oam_next = O_XFER;
            O_XFER:  if (oam_last) oam_next = O_IDLE;
            default: ;
        endcase
        if (wr_ff46) oam_next = O_DELAY;
    end

    // OAM state, source register and byte/delay counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oam_state <= O_IDLE;
            oam_src   <= 8'h00;
            oam_idx   <= 8'h00;
            oam_dly   <= '0;
        end else begin
            oam_state <= oam_next;
            if (wr_ff46) begin
                oam_src <= reg_wdata;
                oam_idx <= 8'h00;
                oam_dly <= '0;
            end else begin
                if (oam_state == O_DELAY) oam_dly <= oam_dly + DLY_W'(1);
                if (oam_rd) oam_idx <= oam_last ? 8'h00 : oam_idx + 8'd1;
            end
        end
    end

    // HDMA only moves data when OAM DMA is not using the read port
    assign hdma_xfer  = (hdma_state == H_GP) || (hdma_state == H_HB_BLOCK);
    assign hdma_rd    = hdma_xfer && !oam_rd;
    assign blk_last   = (byte_cnt == BLK_W'(HDMA_BLOCK - 1));
    assign hb_rise    = hblank && !hblank_q;
    assign hdma_start = wr_ff55 && (hdma_state == H_IDLE);
    assign cancel_req = wr_ff55 && !reg_wdata[7] && (hdma_state == H_HB_BLOCK);
    assign blocks_m1  = blocks_left[6:0] - 7'd1;

    // HDMA next state
    always_comb begin
        hdma_next = hdma_state;
        case (hdma_state)
            H_IDLE:
                if (wr_ff55) hdma_next = reg_wdata[7] ? H_HB_WAIT : H_GP;
            H_GP:
                if (hdma_rd && blk_last && blocks_left == 8'd1) hdma_next = H_IDLE;
            H_HB_WAIT:
                if (wr_ff55 && !reg_wdata[7]) hdma_next = H_IDLE;
                else if (!lcd_on || hb_rise)  hdma_next = H_HB_BLOCK;
            H_HB_BLOCK:
                if (hdma_rd && blk_last)
                    hdma_next = (blocks_left == 8'd1 || cancel_pend || cancel_req)
                                ? H_IDLE : H_HB_WAIT;
            default: hdma_next = H_IDLE;
        endcase
    end

    // HDMA address advance; a register write in the same cycle overrides its byte
    always_comb begin
        src_next = hdma_rd ? hdma_src + 16'd1 : hdma_src;
        dst_next = hdma_rd ? hdma_dst + 13'd1 : hdma_dst;
        if (wr_ff51) src_next[15:8] = reg_wdata;
        if (wr_ff52) src_next[7:0]  = {reg_wdata[7:4], 4'h0};
        if (wr_ff53) dst_next[12:8] = reg_wdata[4:0];
        if (wr_ff54) dst_next[7:0]  = {reg_wdata[7:4], 4'h0};
    end

    // HDMA state, addresses, block/byte counters and deferred cancel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdma_state  <= H_IDLE;
            hdma_src    <= 16'h0000;
            hdma_dst    <= 13'h0000;
            blocks_left <= 8'h00;
            byte_cnt    <= '0;
            cancel_pend <= 1'b0;
            hblank_q    <= 1'b0;
        end else begin
            hdma_state  <= hdma_next;
            hdma_src    <= src_next;
            hdma_dst    <= dst_next;
            hblank_q    <= hblank;
            cancel_pend <= (hdma_next == H_HB_BLOCK) && (cancel_pend || cancel_req);
            if (hdma_start) begin
                blocks_left <= {1'b0, reg_wdata[6:0]} + 8'd1;
                byte_cnt    <= '0;
            end else if (hdma_rd) begin
                byte_cnt <= blk_last ? '0 : byte_cnt + BLK_W'(1);
                if (blk_last) blocks_left <= blocks_left - 8'd1;
            end
        end
    end

    assign rd_en   = oam_rd || hdma_rd;
    assign rd_addr = oam_rd ? {oam_src_eff, oam_idx} : hdma_src;

    // Write stage control: one pending write per read issued last cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            oam_wr_p1  <= 1'b0;
            hdma_wr_p1 <= 1'b0;
        end else begin
            vld_p1     <= rd_en;
            oam_wr_p1  <= oam_rd;
            hdma_wr_p1 <= hdma_rd;
        end
    end

    // Write stage address, captured alongside the read
    always_ff @(posedge clk) begin
        wr_addr_p1 <= oam_rd ? {8'hFE, oam_idx} : {3'b100, hdma_dst};
    end

    assign wr_en     = vld_p1;
    assign wr_addr   = wr_addr_p1;
    assign wr_data   = rd_data;
    assign oam_busy  = (oam_state != O_IDLE) || oam_wr_p1;
    assign cpu_stall = hdma_xfer || hdma_wr_p1;

    // Register read mux; FF55 bit7 reports "not active"
    always_comb begin
        reg_rdata = 8'hFF;
        if (reg_read_en) begin
            if (reg_addr == 16'hFF46)
                reg_rdata = oam_src;
            else if (hdma_map && reg_addr == 16'hFF55)
                reg_rdata = {hdma_state == H_IDLE, blocks_m1};
        end
    end
endmodule

// File: tb/tb_gb_dma_engine.sv
// tb_gb_dma_engine: register vectors, directed DMA sequences and randomized
// transfers checked against an address/data model of the DMA rules.
module tb_gb_dma_engine;
    localparam int OAM_LEN   = 160;
    localparam int OAM_DELAY = 1;

    logic        clk, reset;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata, reg_rdata, rd_data, wr_data;
    logic        reg_write_en, reg_read_en;
    logic        rd_en, wr_en, hblank, lcd_on, oam_busy, cpu_stall;
    logic [15:0] rd_addr, wr_addr;

    gb_dma_engine #(.OAM_LEN(OAM_LEN), .OAM_DELAY(OAM_DELAY), .HDMA_BLOCK(16), .HDMA_EN(1)) dut (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_write_en(reg_write_en), .reg_read_en(reg_read_en), .reg_rdata(reg_rdata),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .hblank(hblank), .lcd_on(lcd_on),
        .oam_busy(oam_busy), .cpu_stall(cpu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [7:0] data; int cyc; } xact_t;
    typedef struct { bit wr; bit rd; logic [15:0] addr; logic [7:0] wdata; logic [7:0] exp; } vec_t;

    xact_t rd_q[$];
    xact_t wr_q[$];
    int    cyc = 0, busy_cnt = 0, stall_cnt = 0;
    int    checks = 0, errors = 0;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and source memory: read data appears the cycle after rd_en
    always @(negedge clk) begin
        if (wr_en) wr_q.push_back('{wr_addr, wr_data, cyc});
        if (rd_en) begin
            rd_q.push_back('{rd_addr, 8'h00, cyc});
            rd_data = mem(rd_addr);
        end
        if (oam_busy)  busy_cnt++;
        if (cpu_stall) stall_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_addr = a; reg_wdata = d; reg_write_en = 1'b1;
        @(negedge clk);
        reg_write_en = 1'b0;
    endtask

    task automatic reg_read(input logic [15:0] a, input logic en, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a; reg_read_en = en;
        #1 d = reg_rdata;
        reg_read_en = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        reg_read(a, 1'b1, d);
        check(name, d, exp);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((oam_busy || cpu_stall) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check({name, " timeout"}, 1, 0);
        @(negedge clk);
    endtask

    task automatic hb_pulse();
        @(negedge clk); hblank = 1'b1;
        repeat (24) @(negedge clk);
        hblank = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] fold(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    // Reads from b_rd: n consecutive addresses from first (OAM keeps the high byte)
    task automatic check_reads(input string tag, input int b_rd, input int n,
                               input logic [15:0] first, input bit oam, input int c0);
        int bad = 0;
        logic [15:0] e;
        check({tag, " read count"}, rd_q.size() - b_rd, n);
        for (int i = 0; i < n && b_rd + i < rd_q.size(); i++) begin
            e = oam ? {first[15:8], 8'(i)} : 16'((int'(first) + i) % 65536);
            if (rd_q[b_rd + i].addr !== e) bad++;
            if (c0 >= 0 && rd_q[b_rd + i].cyc != c0 + i) bad++;
        end
        check({tag, " read seq"}, bad, 0);
    endtask

    // Writes from b_wr split into the OAM stream (FExx) and the VRAM stream
    task automatic check_writes(input string tag, input int b_wr, input int on, input logic [7:0] osrc,
                                input int hn, input logic [15:0] hsrc, input logic [12:0] hdst);
        int oi = 0, hi = 0, bad = 0;
        logic [15:0] ea, sa;
        for (int k = b_wr; k < wr_q.size(); k++) begin
            if (wr_q[k].addr[15:8] == 8'hFE) begin
                ea = {8'hFE, 8'(oi)};
                sa = {fold(osrc), 8'(oi)};
                oi++;
            end else begin
                ea = 16'(32'h8000 + ((int'(hdst) + hi) % 8192));
                sa = 16'((int'(hsrc) + hi) % 65536);
                hi++;
            end
            if (wr_q[k].addr !== ea || wr_q[k].data !== mem(sa)) bad++;
        end
        check({tag, " oam writes"}, oi, on);
        check({tag, " hdma writes"}, hi, hn);
        check({tag, " write data"}, bad, 0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [7:0] d, s51, s52, s53, s54, osrc;
        int b_rd, b_wr, b_busy, b_stall, t0, bad, nb;

        reset = 1'b1; reg_addr = 16'h0; reg_wdata = 8'h0; reg_write_en = 1'b0;
        reg_read_en = 1'b0; hblank = 1'b0; lcd_on = 1'b1;

        vecs.push_back('{0, 1, 16'hFF46, 8'h00, 8'h00});
        vecs.push_back('{0, 1, 16'hFF55, 8'h00, 8'hFF});
        vecs.push_back('{1, 1, 16'hFF51, 8'h12, 8'hFF});
        vecs.push_back('{1, 1, 16'hFF52, 8'h34, 8'hFF});
        vecs.push_back('{1, 1, 16'hFF53, 8'h95, 8'hFF});
        vecs.push_back('{1, 1, 16'hFF54, 8'h67, 8'hFF});
        vecs.push_back('{0, 1, 16'hFF47, 8'h00, 8'hFF});
        vecs.push_back('{0, 0, 16'hFF46, 8'h00, 8'hFF});
        vecs.push_back('{0, 1, 16'hFF55, 8'h00, 8'hFF});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rd_en", rd_en, 0);
        check("reset wr_en", wr_en, 0);
        check("reset oam_busy", oam_busy, 0);
        check("reset cpu_stall", cpu_stall, 0);
        expect_reg("reset FF55", 16'hFF55, 8'hFF);
        @(negedge clk); reset = 1'b0;

        // Register vectors
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].wdata);
            reg_read(vecs[i].addr, vecs[i].rd, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // OAM DMA from C1: timing, addresses, busy window
        b_rd = rd_q.size(); b_wr = wr_q.size(); b_busy = busy_cnt;
        reg_write(16'hFF46, 8'hC1); t0 = cyc;
        expect_reg("FF46 readback", 16'hFF46, 8'hC1);
        wait_idle("oam C1", 400);
        check_reads("oam C1", b_rd, OAM_LEN, 16'hC100, 1, t0 + OAM_DELAY);
        check_writes("oam C1", b_wr, OAM_LEN, 8'hC1, 0, 16'h0, 13'h0);
        bad = 0;
        for (int i = 0; i < OAM_LEN && b_wr + i < wr_q.size() && b_rd + i < rd_q.size(); i++)
            if (wr_q[b_wr + i].cyc != rd_q[b_rd + i].cyc + 1) bad++;
        check("oam C1 write latency", bad, 0);
        check("oam C1 busy cycles", busy_cnt - b_busy, OAM_LEN + 2);

        // Echo source E2 folds to C2
        b_rd = rd_q.size(); b_wr = wr_q.size();
        reg_write(16'hFF46, 8'hE2); t0 = cyc;
        wait_idle("oam E2", 400);
        check_reads("oam E2", b_rd, OAM_LEN, 16'hC200, 1, t0 + OAM_DELAY);
        check_writes("oam E2", b_wr, OAM_LEN, 8'hE2, 0, 16'h0, 13'h0);

        // General-purpose HDMA: 2 blocks 1230 -> 9560
        reg_write(16'hFF51, 8'h12); reg_write(16'hFF52, 8'h34);
        reg_write(16'hFF53, 8'h95); reg_write(16'hFF54, 8'h67);
        b_rd = rd_q.size(); b_wr = wr_q.size(); b_stall = stall_cnt;
        reg_write(16'hFF55, 8'h01); t0 = cyc;
        wait_idle("gp", 200);
        check_reads("gp", b_rd, 32, 16'h1230, 0, t0);
        check_writes("gp", b_wr, 0, 8'h0, 32, 16'h1230, 13'h1560);
        check("gp stall cycles", stall_cnt - b_stall, 33);
        expect_reg("gp FF55 done", 16'hFF55, 8'hFF);

        // HBlank HDMA: 3 blocks, one per hblank rise
        reg_write(16'hFF51, 8'h40); reg_write(16'hFF52, 8'h05);
        reg_write(16'hFF53, 8'h88); reg_write(16'hFF54, 8'h0F);
        b_rd = rd_q.size(); b_wr = wr_q.size(); b_stall = stall_cnt;
        reg_write(16'hFF55, 8'h82);
        repeat (20) @(negedge clk);
        check("hb no early reads", rd_q.size() - b_rd, 0);
        expect_reg("hb FF55 waiting", 16'hFF55, 8'h02);
        for (int k = 0; k < 3; k++) begin
            hb_pulse();
            check($sformatf("hb reads after rise%0d", k), rd_q.size() - b_rd, 16 * (k + 1));
            expect_reg($sformatf("hb FF55 after rise%0d", k), 16'hFF55, (k == 0) ? 8'h01 : (k == 1) ? 8'h00 : 8'hFF);
        end
        check_writes("hb", b_wr, 0, 8'h0, 48, 16'h4000, 13'h0800);
        check("hb stall cycles", stall_cnt - b_stall, 51);

        // HBlank cancel after first of 4 blocks
        reg_write(16'hFF51, 8'h50); reg_write(16'hFF52, 8'h00);
        reg_write(16'hFF53, 8'h80); reg_write(16'hFF54, 8'h00);
        b_rd = rd_q.size(); b_wr = wr_q.size();
        reg_write(16'hFF55, 8'h83);
        hb_pulse();
        expect_reg("cancel FF55 before", 16'hFF55, 8'h02);
        reg_write(16'hFF55, 8'h00);
        expect_reg("cancel FF55 after", 16'hFF55, 8'h82);
        hb_pulse(); hb_pulse();
        check("cancel no more reads", rd_q.size() - b_rd, 16);
        check_writes("cancel", b_wr, 0, 8'h0, 16, 16'h5000, 13'h0000);

        // LCD off: HBlank block starts without an hblank edge
        lcd_on = 1'b0;
        reg_write(16'hFF51, 8'h60); reg_write(16'hFF52, 8'h00);
        reg_write(16'hFF53, 8'h81); reg_write(16'hFF54, 8'h00);
        b_rd = rd_q.size(); b_wr = wr_q.size();
        reg_write(16'hFF55, 8'h80);
        repeat (3) @(negedge clk);
        wait_idle("lcd off", 100);
        check_reads("lcd off", b_rd, 16, 16'h6000, 0, -1);
        check_writes("lcd off", b_wr, 0, 8'h0, 16, 16'h6000, 13'h0100);
        lcd_on = 1'b1;

        // GP HDMA across source/dest wrap, preempted by OAM DMA
        reg_write(16'hFF51, 8'hFF); reg_write(16'hFF52, 8'hF0);
        reg_write(16'hFF53, 8'h9F); reg_write(16'hFF54, 8'hF0);
        b_wr = wr_q.size(); b_stall = stall_cnt; b_busy = busy_cnt;
        reg_write(16'hFF55, 8'h03);
        repeat (9) @(negedge clk);
        reg_write(16'hFF46, 8'hC3);
        wait_idle("preempt", 800);
        check_writes("preempt", b_wr, OAM_LEN, 8'hC3, 64, 16'hFFF0, 13'h1FF0);
        check("preempt stall cycles", stall_cnt - b_stall, 64 + OAM_LEN + 1);
        check("preempt busy cycles", busy_cnt - b_busy, OAM_LEN + 2);

        // Reset in the middle of an OAM DMA
        reg_write(16'hFF46, 8'hC5);
        repeat (30) @(negedge clk);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("midreset oam_busy", oam_busy, 0);
        check("midreset wr_en", wr_en, 0);
        check("midreset rd_en", rd_en, 0);
        b_wr = wr_q.size();
        @(negedge clk);
        check("midreset wr_en next", wr_en, 0);
        @(negedge clk); reset = 1'b0;
        repeat (20) @(negedge clk);
        check("postreset no writes", wr_q.size() - b_wr, 0);
        expect_reg("postreset FF46", 16'hFF46, 8'h00);

        // Randomized GP transfers against the model
        for (int it = 0; it < 6; it++) begin
            s51 = 8'($urandom); s52 = 8'($urandom); s53 = 8'($urandom); s54 = 8'($urandom);
            nb = $urandom_range(1, 3);
            reg_write(16'hFF51, s51); reg_write(16'hFF52, s52);
            reg_write(16'hFF53, s53); reg_write(16'hFF54, s54);
            b_rd = rd_q.size(); b_wr = wr_q.size(); b_stall = stall_cnt;
            reg_write(16'hFF55, 8'(nb - 1)); t0 = cyc;
            wait_idle("rnd gp", 200);
            check_reads($sformatf("rnd gp%0d", it), b_rd, 16 * nb, {s51, s52[7:4], 4'h0}, 0, t0);
            check_writes($sformatf("rnd gp%0d", it), b_wr, 0, 8'h0, 16 * nb,
                         {s51, s52[7:4], 4'h0}, {s53[4:0], s54[7:4], 4'h0});
            check($sformatf("rnd gp%0d stall", it), stall_cnt - b_stall, 16 * nb + 1);
            expect_reg($sformatf("rnd gp%0d FF55", it), 16'hFF55, 8'hFF);
        end

        // Randomized OAM sources, including the echo range
        for (int it = 0; it < 4; it++) begin
            osrc = (it < 2) ? 8'($urandom_range(8'hE0, 8'hFF)) : 8'($urandom_range(0, 8'hDF));
            b_rd = rd_q.size(); b_wr = wr_q.size(); b_busy = busy_cnt;
            reg_write(16'hFF46, osrc); t0 = cyc;
            wait_idle("rnd oam", 400);
            check_reads($sformatf("rnd oam%0d", it), b_rd, OAM_LEN, {fold(osrc), 8'h00}, 1, t0 + OAM_DELAY);
            check_writes($sformatf("rnd oam%0d", it), b_wr, OAM_LEN, osrc, 0, 16'h0, 13'h0);
            check($sformatf("rnd oam%0d busy", it), busy_cnt - b_busy, OAM_LEN + 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gb_dma_engine.md
GB_DMA_ENGINE -- requirements
Module: gb_dma_engine

Interface
REQ-001 Parameters: OAM_LEN, 160, bytes per OAM DMA; OAM_DELAY, 1, idle cycles between FF46 write and first OAM read; HDMA_BLOCK, 16, bytes per HBlank block; HDMA_EN, 1, 0 disables HDMA (FF51-FF55 unmapped, rdata FF).
REQ-002 Ports: clk in 1 clock; reset in 1 asynchronous active-high reset; reg_addr in 16 register address; reg_wdata in 8; reg_write_en in 1; reg_read_en in 1; reg_rdata out 8 (FF when unselected).
REQ-003 Ports: rd_en out 1; rd_addr out 16; rd_data in 8, valid the cycle after rd_en; wr_en out 1; wr_addr out 16; wr_data out 8.
REQ-004 Ports: hblank in 1 PPU HBlank level; lcd_on in 1; oam_busy out 1 (OAM DMA owns OAM); cpu_stall out 1 (HDMA halts CPU).

Function
REQ-005 Registers: FF46 OAM source high byte; FF51/FF52 HDMA source hi/lo, lo[3:0] forced 0; FF53/FF54 HDMA dest hi/lo, hi[7:5] forced 100, lo[3:0] forced 0; FF55 HDMA control.
REQ-006 Reads: FF46 returns last written value; FF51-FF54 return FF; FF55 returns {0, blocks_left-1} while HDMA is active, else {1, blocks_left-1 after a cancel, or 7F}.
REQ-007 Pipeline: byte read at cycle N, written at N+1 with wr_data = rd_data; throughput 1 byte/cycle; only one read issued per cycle.
REQ-008 OAM FSM: IDLE -> DELAY (OAM_DELAY cycles) -> XFER (OAM_LEN reads) -> IDLE after the last write.
REQ-009 OAM addresses: rd_addr = {src', idx}, wr_addr = {FE, idx}, idx 0..OAM_LEN-1; src' = src-20 when src >= E0, else src.
REQ-010 oam_busy is high from the cycle after the FF46 write through the cycle of the last OAM write, inclusive.
REQ-011 FF46 write while OAM is active restarts the transfer: new source, idx=0, DELAY re-entered; the pending write of the in-flight byte still completes.
REQ-012 HDMA FSM: IDLE, GP, HB_WAIT, HB_BLOCK.
REQ-013 FF55 write with bit7=0 from IDLE enters GP and transfers (wdata[6:0]+1)*16 bytes back-to-back, then goes to IDLE.
REQ-014 FF55 write with bit7=1 from IDLE enters HB_WAIT with blocks_left = wdata[6:0]+1.
REQ-015 HB_WAIT -> HB_BLOCK on a hblank rising edge, or immediately on entry if lcd_on=0.
REQ-016 HB_BLOCK transfers HDMA_BLOCK bytes and decrements blocks_left; it then returns to HB_WAIT, or to IDLE when blocks_left reaches 0.
REQ-017 FF55 write with bit7=0 during HB_WAIT cancels: go to IDLE, keep blocks_left; an in-progress HB_BLOCK finishes first, then cancels.
REQ-018 FF55 write while in GP is ignored.
REQ-019 HDMA addressing: source increments with 16-bit wrap; dest is a 13-bit offset from 8000 that wraps 9FFF -> 8000; the transfer continues across the wrap.
REQ-020 cpu_stall is high in GP and HB_BLOCK, including the trailing write cycle.
REQ-021 Arbitration: OAM XFER has priority on the read port; HDMA holds its state and addresses while preempted, and cpu_stall stays asserted.
REQ-022 A register write and an FSM step in the same cycle: the write takes effect and the FSM uses the new values from the next cycle.

Reset
REQ-023 Asynchronous reset: FSMs to IDLE, all counters 0, FF46=00, HDMA registers 0, blocks_left=0.
REQ-024 Outputs during reset: rd_en, wr_en, oam_busy and cpu_stall are 0; FF55 reads FF.
REQ-025 Reset mid-transfer aborts immediately; no write issues in the following cycle.

Verification
REQ-026 FF46<=C1 -> after 1 delay cycle, reads C100..C19F on consecutive cycles; writes FE00..FE9F one cycle later; oam_busy high for 162 cycles.
REQ-027 FF46<=E2 -> reads start at C200.
REQ-028 FF51..54 <= 12,34,95,67 then FF55<=01 -> 32 bytes 1230..124F to 9560..957F; cpu_stall high 33 cycles; FF55 then reads FF.
REQ-029 FF55<=82 with lcd_on=1 -> no transfer until a hblank rise, then 16 bytes per rise; FF55 reads 01 then 00 between blocks; three rises, then IDLE.
REQ-030 HBlank mode, 4 blocks, cancel after the first block -> FF55 reads 82; no further transfers on later hblank rises.
REQ-031 GP HDMA running, FF46 written mid-transfer -> HDMA pauses with cpu_stall high, OAM completes, HDMA resumes at the next address; reset asserted mid-OAM-DMA -> oam_busy=0 and wr_en=0 immediately.
